// File: rtl/kpad_scan_debounce_if.sv
// Keypad front-end signal bundle: matrix rows/columns plus the accepted-key outputs.
// The master side is the scanner; the slave side is the keypad/consumer.
interface kpad_scan_debounce_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  col,
        output row,
        output key,
        output key_valid,
        output key_held
    );

    modport slave (
        output col,
        input  row,
        input  key,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/kpad_scan_debounce.sv
// 4x4 keypad scanner: rotates an active-low row strobe, freezes it while a key is down,
// debounces press and release, and emits one key code per physical press.
module kpad_scan_debounce #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEBOUNCE = 500000
) (
    input  logic           clk,
    input  logic           rst_n,
    kpad_scan_debounce_if.master kp
);

    localparam int unsigned PcW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DcW = $clog2(DEBOUNCE + 1);
    localparam logic [PcW-1:0] PcLast = PcW'(SCAN_DIV - 1);
    localparam logic [DcW-1:0] DcLast = DcW'(DEBOUNCE);
    localparam logic [DcW-1:0] DcOne  = DcW'(1);

    typedef enum logic [1:0] {StScan, StDebPress, StHeld, StDebRel} state_e;

    state_e         state_q, state_d;
    logic [PcW-1:0] pc_q, pc_d;
    logic [DcW-1:0] dc_q, dc_d;
    logic [3:0]     sync_q, cs_q;
    logic [3:0]     pat_q, pat_d;
    logic [3:0]     row_q, row_d;
    logic [3:0]     key_q, key_d;
    logic           key_valid_q, key_valid_d;
    logic           key_held_q, key_held_d;

    logic [3:0]     row_next;
    logic [1:0]     row_idx;
    logic [1:0]     col_idx;
    logic [3:0]     key_code;

    assign row_next = {row_q[2:0], row_q[3]};

    always_comb begin
        row_idx = 2'd0;
        unique case (row_q)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    // Lowest low column wins when several are pressed together.
    always_comb begin
        if (!pat_q[0]) begin
            col_idx = 2'd0;
        end else if (!pat_q[1]) begin
            col_idx = 2'd1;
        end else if (!pat_q[2]) begin
            col_idx = 2'd2;
        end else begin
            col_idx = 2'd3;
        end
    end

    always_comb begin
        key_code = 4'h0;
        case ({row_idx, col_idx})
            4'h0: key_code = 4'h1;
            4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;
            4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;
            4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;
            4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;
            4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;
            4'hB: key_code = 4'hC;
            4'hC: key_code = 4'h0;
            4'hD: key_code = 4'hF;
            4'hE: key_code = 4'hE;
            4'hF: key_code = 4'hD;
            default: key_code = 4'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        dc_d        = dc_q;
        pat_d       = pat_q;
        row_d       = row_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        case (state_q)
            StScan: begin
                if (pc_q == PcLast) begin
                    pc_d = '0;
                    if (cs_q != 4'b1111) begin
                        pat_d   = cs_q;
                        dc_d    = DcOne;
                        state_d = StDebPress;
                    end else begin
                        row_d = row_next;
                    end
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            StDebPress: begin
                // Any change, including on the final count, abandons the press.
                if (cs_q != pat_q) begin
                    pc_d    = '0;
                    row_d   = row_next;
                    state_d = StScan;
                end else if (dc_q == DcLast) begin
                    key_d       = key_code;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = StHeld;
                end else begin
                    dc_d = dc_q + 1'b1;
                end
            end
            StHeld: begin
                if (cs_q == 4'b1111) begin
                    dc_d    = DcOne;
                    state_d = StDebRel;
                end
            end
            StDebRel: begin
                if (cs_q != 4'b1111) begin
                    state_d = StHeld;
                end else if (dc_q == DcLast) begin
                    key_held_d = 1'b0;
                    row_d      = row_next;
                    pc_d       = '0;
                    state_d    = StScan;
                end else begin
                    dc_d = dc_q + 1'b1;
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StScan;
            pc_q        <= '0;
            dc_q        <= '0;
            sync_q      <= 4'b1111;
            cs_q        <= 4'b1111;
            pat_q       <= 4'b1111;
            row_q       <= 4'b1110;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            dc_q        <= dc_d;
            sync_q      <= kp.col;
            cs_q        <= sync_q;
            pat_q       <= pat_d;
            row_q       <= row_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.row       = row_q;
    assign kp.key       = key_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_kpad_scan_debounce.sv
// Directed bench for kpad_scan_debounce with SCAN_DIV=4, DEBOUNCE=8; columns are modelled
// from the driven row and a table of pressed keys.
module tb_kpad_scan_debounce;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pressed = 16'h0000;
    int          n_tests = 0;
    int          n_fail = 0;
    int          kv_cnt = 0;

    kpad_scan_debounce_if kif ();

    kpad_scan_debounce #(
        .SCAN_DIV(4),
        .DEBOUNCE(8)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kif)
    );

    always #5 clk = ~clk;

    // Key (r, c) pulls column c low while row r is driven low.
    always_comb begin
        kif.col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kif.row[r]) kif.col[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) if (kif.key_valid === 1'b1) kv_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_kv(input string tag, output int lat);
        lat = 0;
        while (kif.key_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_kv_seen"}, {31'd0, kif.key_valid}, 32'd1);
    endtask

    task automatic wait_rel(input string tag);
        int n;
        n = 0;
        while (kif.key_held !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_released"}, {31'd0, kif.key_held}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k0;
        int bad;
        logic [3:0] exp_row;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_row", {28'd0, kif.row}, 32'h0000000E);
        check("rst_key", {28'd0, kif.key}, 32'h0);
        check("rst_kv", {31'd0, kif.key_valid}, 32'd0);
        check("rst_held", {31'd0, kif.key_held}, 32'd0);

        // 1: idle scan, row rotates every 4 cycles
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 3 || n % 4 == 0) begin
                case (n)
                    3:       exp_row = 4'b1110;
                    4:       exp_row = 4'b1101;
                    8:       exp_row = 4'b1011;
                    12:      exp_row = 4'b0111;
                    default: exp_row = 4'b1110;
                endcase
                check($sformatf("t1_row_n%0d", n), {28'd0, kif.row}, {28'd0, exp_row});
            end
        end
        check("t1_no_kv", kv_cnt, 0);
        check("t1_key", {28'd0, kif.key}, 32'h0);

        // 2: clean press of '5', hold, release
        pressed = 16'h1 << 5;
        wait_kv("t2", lat);
        check("t2_lat_le26", {31'd0, lat <= 26}, 32'd1);
        check("t2_key", {28'd0, kif.key}, 32'h5);
        check("t2_held", {31'd0, kif.key_held}, 32'd1);
        check("t2_row", {28'd0, kif.row}, 32'h0000000D);
        @(negedge clk);
        check("t2_pulse_width", {31'd0, kif.key_valid}, 32'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kif.row !== 4'b1101) bad++;
        end
        check("t2_row_frozen", bad, 0);
        check("t2_one_kv", kv_cnt, 1);
        pressed = 16'h0;
        repeat (10) @(negedge clk);
        check("t2_held_at_10", {31'd0, kif.key_held}, 32'd1);
        @(negedge clk);
        check("t2_held_at_11", {31'd0, kif.key_held}, 32'd0);
        check("t2_row_resume", {28'd0, kif.row}, 32'h0000000B);
        check("t2_key_kept", {28'd0, kif.key}, 32'h5);
        repeat (6) @(negedge clk);

        // 3: 'D' with three 2-cycle bounces
        k0 = kv_cnt;
        for (int b = 0; b < 3; b++) begin
            pressed = 16'h1 << 15;
            repeat (2) @(negedge clk);
            pressed = 16'h0;
            repeat (2) @(negedge clk);
        end
        check("t3_no_kv_bounce", kv_cnt, k0);
        pressed = 16'h1 << 15;
        wait_kv("t3", lat);
        check("t3_key", {28'd0, kif.key}, 32'h0000000D);
        repeat (20) @(negedge clk);
        check("t3_one_kv", kv_cnt, k0 + 1);
        pressed = 16'h0;
        wait_rel("t3");
        repeat (6) @(negedge clk);

        // 4: hold 'A', release with one bounce
        pressed = 16'h1 << 3;
        wait_kv("t4", lat);
        check("t4_key", {28'd0, kif.key}, 32'h0000000A);
        repeat (10) @(negedge clk);
        k0 = kv_cnt;
        pressed = 16'h0;
        repeat (5) @(negedge clk);
        pressed = 16'h1 << 3;
        @(negedge clk);
        pressed = 16'h0;
        repeat (10) @(negedge clk);
        check("t4_held_at_16", {31'd0, kif.key_held}, 32'd1);
        @(negedge clk);
        check("t4_held_at_17", {31'd0, kif.key_held}, 32'd0);
        check("t4_row_resume", {28'd0, kif.row}, 32'h0000000D);
        check("t4_no_second_kv", kv_cnt, k0);
        repeat (6) @(negedge clk);

        // 5: '4' and '6' together, lowest column wins
        pressed = (16'h1 << 4) | (16'h1 << 6);
        wait_kv("t5", lat);
        check("t5_key", {28'd0, kif.key}, 32'h4);
        @(negedge clk);
        pressed = 16'h0;
        wait_rel("t5");
        repeat (6) @(negedge clk);

        // 6: reset while holding '9'
        pressed = 16'h1 << 10;
        wait_kv("t6", lat);
        check("t6_key", {28'd0, kif.key}, 32'h9);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_key", {28'd0, kif.key}, 32'h0);
        check("t6_rst_held", {31'd0, kif.key_held}, 32'd0);
        check("t6_rst_row", {28'd0, kif.row}, 32'h0000000E);
        check("t6_rst_kv", {31'd0, kif.key_valid}, 32'd0);
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        k0 = kv_cnt;
        repeat (30) @(negedge clk);
        check("t6_no_kv_after_rst", kv_cnt, k0);
        pressed = 16'h1 << 10;
        wait_kv("t6b", lat);
        check("t6b_key", {28'd0, kif.key}, 32'h9);
        @(negedge clk);
        pressed = 16'h0;
        wait_rel("t6b");

        check("total_kv", kv_cnt, 6);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
